// File: rtl/dti_bcast_buf.sv
// Two-way broadcast buffer: one input stream fanned out to two independently
// stalling outputs, sharing a circular buffer with one read pointer per branch.
module dti_bcast_buf #(
  parameter int TDIN  = 16,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TDIN-1:0] din_data_i,
  input  logic            din_valid_i,
  output logic            din_ready_o,
  output logic [TDIN-1:0] dout0_data_o,
  output logic            dout0_valid_o,
  input  logic            dout0_ready_i,
  output logic [TDIN-1:0] dout1_data_o,
  output logic            dout1_valid_o,
  input  logic            dout1_ready_i
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("dti_bcast_buf: DEPTH must be a power of two >= 2");
  end

  logic                 push;
  logic [PW-1:0]        wr_q, wr_d;
  logic [1:0][PW-1:0]   rd_q, rd_d;
  logic [1:0][CW-1:0]   cnt_q, cnt_d;
  logic [1:0]           vld;
  logic [1:0]           pop;
  logic [1:0]           br_rdy;
  logic [TDIN-1:0]      mem_q [DEPTH];

  assign br_rdy = {dout1_ready_i, dout0_ready_i};

  // Ready looks only at registered counters, so no path from either dout ready.
  assign din_ready_o = (cnt_q[0] < FULL) && (cnt_q[1] < FULL) && rst;
  assign push        = din_valid_i && din_ready_o;

  always_comb begin
    vld = '0;
    pop = '0;
    for (int k = 0; k < 2; k++) begin
      vld[k] = (cnt_q[k] != '0);
      pop[k] = vld[k] && br_rdy[k];
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      wr_d = wr_q + PW'(1);
    end
    for (int k = 0; k < 2; k++) begin
      if (pop[k]) begin
        rd_d[k] = rd_q[k] + PW'(1);
      end
      // A push and a pop in the same cycle cancel on this branch's count.
      case ({push, pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; push is already gated by rst through din_ready_o.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= din_data_i;
    end
  end

  assign dout0_valid_o = vld[0];
  assign dout1_valid_o = vld[1];
  assign dout0_data_o  = mem_q[rd_q[0]];
  assign dout1_data_o  = mem_q[rd_q[1]];

endmodule

// File: tb/tb_dti_bcast_buf.sv
// Bench for dti_bcast_buf: DEPTH=2 and DEPTH=4 instances share stimulus and
// are each checked every cycle against a per-branch queue model.
module tb_dti_bcast_buf;

  logic        clk;
  logic        rst;
  logic [15:0] din_data;
  logic        din_valid;
  logic        r0, r1;

  logic        rdy_a, v0_a, v1_a, rdy_b, v0_b, v1_b;
  logic [15:0] d0_a, d1_a, d0_b, d1_b;

  int vectors;
  int miscompares;
  int cyc;

  logic [15:0] qa0[$], qa1[$], qb0[$], qb1[$];
  logic [15:0] obs0[$], obs1[$];
  bit          push_a, push_b;

  dti_bcast_buf #(.TDIN(16), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .din_data_i(din_data), .din_valid_i(din_valid), .din_ready_o(rdy_a),
    .dout0_data_o(d0_a), .dout0_valid_o(v0_a), .dout0_ready_i(r0),
    .dout1_data_o(d1_a), .dout1_valid_o(v1_a), .dout1_ready_i(r1)
  );

  dti_bcast_buf #(.TDIN(16), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .din_data_i(din_data), .din_valid_i(din_valid), .din_ready_o(rdy_b),
    .dout0_data_o(d0_b), .dout0_valid_o(v0_b), .dout0_ready_i(r0),
    .dout1_data_o(d1_b), .dout1_valid_o(v1_b), .dout1_ready_i(r1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_chk(input string tag, input int depth, input int n0, input int n1,
                           input logic [15:0] h0, input logic [15:0] h1,
                           input logic ar, input logic av0, input logic av1,
                           input logic [15:0] ad0, input logic [15:0] ad1);
    logic er;
    er = rst && (n0 < depth) && (n1 < depth);
    chk({tag, ".din_ready"}, 32'(ar), 32'(er));
    chk({tag, ".dout0_valid"}, 32'(av0), 32'(n0 != 0));
    chk({tag, ".dout1_valid"}, 32'(av1), 32'(n1 != 0));
    if (n0 != 0) chk({tag, ".dout0_data"}, 32'(ad0), 32'(h0));
    if (n1 != 0) chk({tag, ".dout1_data"}, 32'(ad1), 32'(h1));
  endtask

  task automatic clear_model();
    qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    int na0, na1, nb0, nb1;
    bit pa0, pa1, pb0, pb1;
    @(negedge clk);
    na0 = qa0.size(); na1 = qa1.size(); nb0 = qb0.size(); nb1 = qb1.size();
    model_chk("d2", 2, na0, na1, (na0 != 0) ? qa0[0] : 16'h0, (na1 != 0) ? qa1[0] : 16'h0,
              rdy_a, v0_a, v1_a, d0_a, d1_a);
    model_chk("d4", 4, nb0, nb1, (nb0 != 0) ? qb0[0] : 16'h0, (nb1 != 0) ? qb1[0] : 16'h0,
              rdy_b, v0_b, v1_b, d0_b, d1_b);
    push_a = rst && din_valid && (na0 < 2) && (na1 < 2);
    push_b = rst && din_valid && (nb0 < 4) && (nb1 < 4);
    pa0 = rst && r0 && (na0 != 0);
    pa1 = rst && r1 && (na1 != 0);
    pb0 = rst && r0 && (nb0 != 0);
    pb1 = rst && r1 && (nb1 != 0);
    if (pa0) obs0.push_back(d0_a);
    if (pa1) obs1.push_back(d1_a);
    @(posedge clk);
    cyc++;
    if (!rst) begin
      clear_model();
    end else begin
      if (pa0) void'(qa0.pop_front());
      if (pa1) void'(qa1.pop_front());
      if (pb0) void'(qb0.pop_front());
      if (pb1) void'(qb1.pop_front());
      if (push_a) begin qa0.push_back(din_data); qa1.push_back(din_data); end
      if (push_b) begin qb0.push_back(din_data); qb1.push_back(din_data); end
    end
    #1;
  endtask

  // Present a word until the DEPTH=2 instance takes it.
  task automatic send(input logic [15:0] w);
    din_valid = 1'b1;
    din_data  = w;
    for (int i = 0; i < 16; i++) begin
      step();
      if (push_a) begin
        din_valid = 1'b0;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: word %0h not accepted within 16 cycles", w);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    din_valid = 1'b0;
    r0 = 1'b1;
    r1 = 1'b1;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic chk_seq(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c);
    chk({nm, ".obs0_len"}, 32'(obs0.size()), 32'd3);
    chk({nm, ".obs1_len"}, 32'(obs1.size()), 32'd3);
    if (obs0.size() == 3) begin
      chk({nm, ".obs0_0"}, 32'(obs0[0]), 32'(a));
      chk({nm, ".obs0_1"}, 32'(obs0[1]), 32'(b));
      chk({nm, ".obs0_2"}, 32'(obs0[2]), 32'(c));
    end
    if (obs1.size() == 3) begin
      chk({nm, ".obs1_0"}, 32'(obs1[0]), 32'(a));
      chk({nm, ".obs1_1"}, 32'(obs1[1]), 32'(b));
      chk({nm, ".obs1_2"}, 32'(obs1[2]), 32'(c));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int words;
    vectors = 0; miscompares = 0; cyc = 0;
    rst = 1'b0; din_valid = 1'b0; din_data = '0; r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("reset_rdy", 32'(rdy_a), 32'd0);
    chk("reset_v0", 32'(v0_a), 32'd0);
    rst = 1'b1;
    #1;
    chk("release_rdy", 32'(rdy_a), 32'd1);
    chk("release_v1", 32'(v1_a), 32'd0);
    step();

    // Streaming 1..8 with both readies high.
    r0 = 1'b1; r1 = 1'b1;
    obs0.delete(); obs1.delete();
    c0 = cyc;
    for (int w = 1; w <= 8; w++) begin
      send(16'(w));
      chk("stream_rdy", 32'(rdy_a), 32'd1);
      if (w == 1) begin
        chk("stream_first_v0", 32'(v0_a), 32'd1);
        chk("stream_first_d0", 32'(d0_a), 32'h0001);
        chk("stream_first_d1", 32'(d1_a), 32'h0001);
      end
    end
    chk("stream_cycles", 32'(cyc - c0), 32'd8);
    drain();
    chk("stream_obs0_len", 32'(obs0.size()), 32'd8);
    chk("stream_obs1_len", 32'(obs1.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs0.size() && i < obs1.size(); i++) begin
      chk("stream_obs0", 32'(obs0[i]), 32'(i + 1));
      chk("stream_obs1", 32'(obs1[i]), 32'(i + 1));
    end

    // One-sided stall on branch 1.
    obs0.delete(); obs1.delete();
    r0 = 1'b1; r1 = 1'b0;
    send(16'h000A);
    send(16'h000B);
    chk("stall_rdy_low", 32'(rdy_a), 32'd0);
    chk("stall_d1_head", 32'(d1_a), 32'h000A);
    din_valid = 1'b1; din_data = 16'h000C;
    for (int i = 0; i < 3; i++) step();
    chk("stall_held", 32'(rdy_a), 32'd0);
    r1 = 1'b1;
    for (int i = 0; i < 8 && !push_a; i++) step();
    chk("stall_c_accepted", 32'(push_a), 32'd1);
    drain();
    chk_seq("stall", 16'h000A, 16'h000B, 16'h000C);

    // Push and pop on branch 0 in the same cycle while it holds one word.
    obs0.delete(); obs1.delete();
    r0 = 1'b0; r1 = 1'b1;
    send(16'h0011);
    r0 = 1'b1;
    send(16'h0012);
    chk("pp_v0", 32'(v0_a), 32'd1);
    chk("pp_d0", 32'(d0_a), 32'h0012);
    chk("pp_model_cnt0", 32'(qa0.size()), 32'd1);
    send(16'h0013);
    chk("pp_d0_next", 32'(d0_a), 32'h0013);
    drain();
    chk_seq("pp", 16'h0011, 16'h0012, 16'h0013);

    // Random readies and valid; count words taken by the DEPTH=4 instance.
    words = 0;
    for (int i = 0; i < 2000 && words < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!din_valid || push_b) begin
        din_valid = 1'($urandom_range(0, 3) != 0);
        din_data  = 16'($urandom);
      end
      step();
      if (push_b) words++;
    end
    chk("random_words", 32'(words >= 20), 32'd1);
    drain();

    // Asynchronous reset with two words pending on branch 1.
    r0 = 1'b1; r1 = 1'b0;
    send(16'h0021);
    send(16'h0022);
    chk("prereset_v1", 32'(v1_a), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_v0", 32'(v0_a), 32'd0);
    chk("areset_v1", 32'(v1_a), 32'd0);
    chk("areset_rdy", 32'(rdy_a), 32'd0);
    chk("areset_v1_d4", 32'(v1_b), 32'd0);
    clear_model();
    step();
    step();
    rst = 1'b1;
    r0 = 1'b1; r1 = 1'b1;
    #1;
    chk("rerelease_rdy", 32'(rdy_a), 32'd1);
    chk("rerelease_v1", 32'(v1_a), 32'd0);
    send(16'h0055);
    chk("after_v0", 32'(v0_a), 32'd1);
    chk("after_v1", 32'(v1_a), 32'd1);
    chk("after_d0", 32'(d0_a), 32'h0055);
    chk("after_d1", 32'(d1_a), 32'h0055);
    step();
    chk("after_alone_v0", 32'(v0_a), 32'd0);
    chk("after_alone_v1", 32'(v1_a), 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
